fetch_unit: RTL and testbench

- Instruction-issue side of the 4-bit CPU: holds a 16-entry program store, keeps the program counter and drives opcode/op1/op2 to the decoder FSM.
- Uses a valid/ready handshake to issue each instruction, then waits for the decoder to report execution complete before advancing.
- The decoder may request a jump on completion. The unit stops on the HALT opcode.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/prog_store.sv | 30 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU instruction-issue path.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int FIELD_W = 4;
  localparam int INSTR_W = 3 * FIELD_W;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [FIELD_W-1:0] HALT_OP = 4'hF;

  // Field positions inside an instruction word {opcode, op1, op2}
  localparam int OPC_LSB = 2 * FIELD_W;
  localparam int OP1_LSB = FIELD_W;
  localparam int OP2_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC,
    HALT
  } fetch_state_t;

  function automatic logic [FIELD_W-1:0] word_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/prog_store.sv
// 16 x 12 program store: one synchronous write port, one combinational
// read port, whole array cleared by reset.
module prog_store
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port with async clear of every word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue unit: program counter, program store and the
// valid/ready issue handshake towards the decoder.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               ex_done,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] op1,
  output logic [FIELD_W-1:0] op2,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic               valid_reg, valid_next;
  logic [INSTR_W-1:0] mem_word;
  logic               store_we;

  // The store is only writable while nothing is executing
  assign store_we = load_en && ((state_reg == IDLE) || (state_reg == HALT));

  prog_store u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (store_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (mem_word)
  );

  // State, pc, issued word and valid flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state, pc sequencing and issue handshake
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (start) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        instr_next = mem_word;
        // A HALT word is latched for visibility but never offered to the decoder
        if (word_opcode(mem_word) == HALT_OP) begin
          state_next = HALT;
        end else begin
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          valid_next = 1'b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (ex_done) begin
          pc_next    = jump_en ? jump_addr : pc_reg + 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign instr_valid = valid_reg;
  assign opcode      = instr_reg[OPC_LSB +: FIELD_W];
  assign op1         = instr_reg[OP1_LSB +: FIELD_W];
  assign op2         = instr_reg[OP2_LSB +: FIELD_W];
  assign pc          = pc_reg;
  assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle vector table, directed
// multi-cycle sequences and a randomized run against a program-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic        instr_valid;
  logic        instr_ready;
  logic        ex_done;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic [3:0]  opcode;
  logic [3:0]  op1;
  logic [3:0]  op2;
  logic [3:0]  pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ex_done     (ex_done),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .opcode      (opcode),
    .op1         (op1),
    .op2         (op2),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        ready;
    logic        ex_done;
    logic        jump_en;
    logic [3:0]  jump_addr;
    logic        e_valid;
    logic [11:0] e_fields;
    logic [3:0]  e_pc;
    logic        e_halted;
  } vec_t;

  vec_t vecs [12];

  // Program-level reference model
  logic [11:0] model_mem [16];
  logic [3:0]  model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start       = 1'b0;
    load_en     = 1'b0;
    load_addr   = 4'h0;
    load_data   = 12'h000;
    instr_ready = 1'b0;
    ex_done     = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 4'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 12'h000;
    model_pc = 4'h0;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [11:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for either an offered instruction or HALT
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && !halted && n < 8) begin
      tick();
      n++;
    end
    if (!instr_valid && !halted) chk({tag, " wait"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // One full instruction: check the offer, handshake, then ex_done one cycle later
  task automatic issue_one(input string tag, input logic [11:0] exp_word, input logic [3:0] exp_pc,
                           input logic jmp, input logic [3:0] jaddr);
    wait_valid(tag);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " fields"}, {20'd0, opcode, op1, op2}, {20'd0, exp_word});
    chk({tag, " pc"}, {28'd0, pc}, {28'd0, exp_pc});
    $display("issue %s op=%h op1=%h op2=%h pc=%0d", tag, opcode, op1, op2, pc);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk({tag, " accepted"}, {31'd0, instr_valid}, 32'd0);
    tick();
    ex_done   = 1'b1;
    jump_en   = jmp;
    jump_addr = jaddr;
    tick();
    ex_done = 1'b0;
    jump_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic l, input logic [3:0] la, input logic [11:0] ld,
                              input logic r, input logic ed, input logic je, input logic [3:0] ja,
                              input logic ev, input logic [11:0] ef, input logic [3:0] ep, input logic eh);
    vec_t v;
    v = '{s, l, la, ld, r, ed, je, ja, ev, ef, ep, eh};
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    logic [3:0]  a;
    logic        exp_halt;
    logic        jmp;

    rst = 1'b1;
    clear_inputs();
    #2;
    chk("reset valid", {31'd0, instr_valid}, 32'd0);
    chk("reset pc", {28'd0, pc}, 32'd0);
    chk("reset fields", {20'd0, opcode, op1, op2}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    do_reset();

    // ---------------- basic program as a cycle table ----------------
    //             start  load  addr   data      rdy   exd   jmp   jaddr | valid fields    pc    halted
    vecs[0]  = mk(1'b0, 1'b1, 4'h0, 12'h123, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 4'h1, 12'h456, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 4'h2, 12'hF00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h123, 4'h0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 12'h123, 4'h1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 12'h456, 4'h1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h456, 4'h1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h456, 4'h2, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'hF00, 4'h2, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'hF00, 4'h2, 1'b1);

    for (int i = 0; i < 12; i++) begin
      start       = vecs[i].start;
      load_en     = vecs[i].load_en;
      load_addr   = vecs[i].load_addr;
      load_data   = vecs[i].load_data;
      instr_ready = vecs[i].ready;
      ex_done     = vecs[i].ex_done;
      jump_en     = vecs[i].jump_en;
      jump_addr   = vecs[i].jump_addr;
      tick();
      $display("vec %0d valid=%b fields=%h pc=%0d halted=%b", i, instr_valid, {opcode, op1, op2}, pc, halted);
      chk($sformatf("vec%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d fields", i), {20'd0, opcode, op1, op2}, {20'd0, vecs[i].e_fields});
      chk($sformatf("vec%0d pc", i), {28'd0, pc}, {28'd0, vecs[i].e_pc});
      chk($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
    end
    clear_inputs();

    // ---------------- backpressure ----------------
    do_reset();
    load_word(4'h0, 12'h123);
    load_word(4'h1, 12'hF00);
    pulse_start();
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold%0d valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("bp hold%0d fields", i), {20'd0, opcode, op1, op2}, 32'h123);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("bp handshake", {31'd0, instr_valid}, 32'd0);
    $display("issue bp op=%h op1=%h op2=%h pc=%0d", opcode, op1, op2, pc);
    tick();
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    wait_valid("bp halt");
    chk("bp halted", {31'd0, halted}, 32'd1);
    chk("bp halt pc", {28'd0, pc}, 32'd1);
    chk("bp halt valid", {31'd0, instr_valid}, 32'd0);

    // ---------------- jump, wrap, ignored inputs, reload ----------------
    do_reset();
    load_word(4'h0, 12'h123);
    load_word(4'h1, 12'h456);
    load_word(4'h7, 12'h9AB);
    load_word(4'h8, 12'hF00);
    load_word(4'hF, 12'h211);
    pulse_start();
    issue_one("j0", 12'h123, 4'h0, 1'b0, 4'h0);
    issue_one("j1", 12'h456, 4'h1, 1'b1, 4'h7);
    issue_one("j7", 12'h9AB, 4'h7, 1'b1, 4'hF);
    issue_one("wrap15", 12'h211, 4'hF, 1'b0, 4'h0);
    wait_valid("wrap0");
    chk("wrap0 fields", {20'd0, opcode, op1, op2}, 32'h123);
    chk("wrap0 pc", {28'd0, pc}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    // load and start while executing must have no effect
    load_en   = 1'b1;
    load_addr = 4'h0;
    load_data = 12'h777;
    start     = 1'b1;
    tick();
    clear_inputs();
    chk("ign valid", {31'd0, instr_valid}, 32'd0);
    chk("ign pc", {28'd0, pc}, 32'd0);
    chk("ign fields", {20'd0, opcode, op1, op2}, 32'h123);
    tick();
    ex_done   = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 4'h0;
    tick();
    clear_inputs();
    issue_one("ign mem0", 12'h123, 4'h0, 1'b1, 4'h8);
    wait_valid("j halt");
    chk("j halted", {31'd0, halted}, 32'd1);
    chk("j halt pc", {28'd0, pc}, 32'd8);
    chk("j halt valid", {31'd0, instr_valid}, 32'd0);
    load_word(4'h0, 12'hCDE);
    chk("reload still halted", {31'd0, halted}, 32'd1);
    pulse_start();
    chk("restart halted drops", {31'd0, halted}, 32'd0);
    chk("restart pc", {28'd0, pc}, 32'd0);
    wait_valid("reload");
    chk("reload fields", {20'd0, opcode, op1, op2}, 32'hCDE);
    chk("reload valid", {31'd0, instr_valid}, 32'd1);

    // ---------------- asynchronous reset mid-ISSUE ----------------
    #2;
    rst = 1'b1;
    #1;
    chk("arst valid", {31'd0, instr_valid}, 32'd0);
    chk("arst pc", {28'd0, pc}, 32'd0);
    chk("arst fields", {20'd0, opcode, op1, op2}, 32'd0);
    chk("arst halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    pulse_start();
    issue_one("arst w0", 12'h000, 4'h0, 1'b0, 4'h0);
    issue_one("arst w1", 12'h000, 4'h1, 1'b0, 4'h0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = {(($urandom_range(5) == 0) ? 4'hF : 4'($urandom_range(14))), 4'($urandom), 4'($urandom)};
      load_word(4'(i), w);
    end
    pulse_start();
    model_pc = 4'h0;
    for (int step = 0; step < 150; step++) begin
      wait_valid("rnd");
      exp_halt = (model_mem[model_pc][11:8] == 4'hF);
      chk("rnd halted", {31'd0, halted}, {31'd0, exp_halt});
      chk("rnd pc", {28'd0, pc}, {28'd0, model_pc});
      if (halted) begin
        $display("halt rnd step=%0d pc=%0d", step, pc);
        for (int k = 0; k < 3; k++) begin
          a = 4'($urandom);
          w = {(($urandom_range(5) == 0) ? 4'hF : 4'($urandom_range(14))), 4'($urandom), 4'($urandom)};
          load_word(a, w);
        end
        pulse_start();
        model_pc = 4'h0;
      end else begin
        chk("rnd fields", {20'd0, opcode, op1, op2}, {20'd0, model_mem[model_pc]});
        $display("issue rnd step=%0d op=%h op1=%h op2=%h pc=%0d", step, opcode, op1, op2, pc);
        for (int k = 0; k < int'($urandom_range(3)); k++) begin
          load_en   = $urandom_range(1) == 1;
          load_addr = 4'($urandom);
          load_data = 12'($urandom);
          start     = $urandom_range(1) == 1;
          tick();
          clear_inputs();
          chk("rnd bp valid", {31'd0, instr_valid}, 32'd1);
          chk("rnd bp fields", {20'd0, opcode, op1, op2}, {20'd0, model_mem[model_pc]});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("rnd accepted", {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < int'($urandom_range(3)); k++) begin
          load_en   = $urandom_range(1) == 1;
          load_addr = 4'($urandom);
          load_data = 12'($urandom);
          start     = $urandom_range(1) == 1;
          jump_en   = $urandom_range(1) == 1;
          jump_addr = 4'($urandom);
          tick();
          clear_inputs();
          chk("rnd exec pc", {28'd0, pc}, {28'd0, model_pc});
        end
        jmp       = ($urandom_range(3) == 0);
        ex_done   = 1'b1;
        jump_en   = jmp;
        jump_addr = 4'($urandom);
        model_pc  = jmp ? jump_addr : 4'((int'(model_pc) + 1) % 16);
        tick();
        clear_inputs();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
